// File: rtl/dom_rng_pkg.sv
// ============================================================================
// Module  : dom_rng_pkg
// Purpose : Shared constants, FSM state type and width helper for the DOM
//           fresh-randomness generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dom_rng_pkg;

  localparam logic [63:0] c_lane_inc = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] c_zero_sub = 64'h0000000000000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    WARM = 2'd2,
    RUN  = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] z_w;
    logic [31:0] b_w;
  } mul_width_t;

  // Fresh bits one DOM multiplier consumes per cycle for a given share count.
  function automatic mul_width_t mul_widths(input int shares);
    mul_width_t w;
    w.z_w = 32'(shares * (shares - 1));
    w.b_w = 32'(2 * shares);
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xorshift64_lane.sv
// ============================================================================
// Module  : xorshift64_lane
// Purpose : One 64-bit xorshift64 state register with load, step and hold.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xorshift64_lane #(
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [63:0]      i_load_val,
  input  logic             i_step,
  output logic [OUT_W-1:0] o_state,
  output logic [OUT_W-1:0] o_next
);

  logic [63:0] r_state;
  logic [63:0] w_s1;
  logic [63:0] w_s2;
  logic [63:0] w_s3;

  assign w_s1 = r_state ^ (r_state << 13);
  assign w_s2 = w_s1 ^ (w_s1 >> 7);
  assign w_s3 = w_s2 ^ (w_s2 << 17);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
    end else if (i_load) begin
      r_state <= i_load_val;
    end else if (i_step) begin
      r_state <= w_s3;
    end
  end

  // Only the bits the top actually forwards are exposed; the step uses all 64.
  assign o_state = r_state[OUT_W-1:0];
  assign o_next  = w_s3[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/dom_mask_rng.sv
// ============================================================================
// Module  : dom_mask_rng
// Purpose : Seeded xorshift64 source of Z (remask) and B (blinding) bits for
//           NUM_MULS DOM GF(2^2) multipliers. Optional macro
//           DOM_RNG_RESEED_LIMIT_EN adds a step budget and ReseedReqxSO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dom_mask_rng
  import dom_rng_pkg::*;
#(
  parameter int SHARES        = 2,
  parameter int NUM_MULS      = 9,
  parameter int WARMUP_CYCLES = 16
`ifdef DOM_RNG_RESEED_LIMIT_EN
  ,
  parameter int RESEED_LIMIT  = 1024
`endif
) (
  input  logic                                  ClkxCI,
  input  logic                                  RstxRI,
  input  logic [63:0]                           SeedxDI,
  input  logic                                  SeedValidxSI,
  output logic                                  SeedReadyxSO,
  input  logic                                  EnxSI,
  output logic [NUM_MULS*SHARES*(SHARES-1)-1:0] RandZxDO,
  output logic [NUM_MULS*2*SHARES-1:0]          RandBxDO,
  output logic                                  RandValidxSO
`ifdef DOM_RNG_RESEED_LIMIT_EN
  ,
  output logic                                  ReseedReqxSO
`endif
);

  localparam mul_width_t c_mw = mul_widths(SHARES);
  localparam int Z_W   = NUM_MULS * int'(c_mw.z_w);
  localparam int B_W   = NUM_MULS * int'(c_mw.b_w);
  localparam int c_tot = Z_W + B_W;
  localparam int LANES = (c_tot + 63) / 64;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [31:0]        r_warm_cnt;
  logic [63:0]        r_seed;
  logic [c_tot-1:0]   r_out;
  logic               r_valid;
  logic               r_ready;
  logic [c_tot-1:0]   w_cat_cur;
  logic [c_tot-1:0]   w_cat_nxt;
  logic               w_seed_hs;
  logic               w_lane_load;
  logic               w_lane_step;
  logic               w_out_cur;
  logic               w_out_nxt;
  logic               w_valid_nxt;
  logic               w_frozen;
  logic               w_limit_hit;

  assign w_seed_hs = SeedValidxSI & r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_lane_load = 1'b0;
    w_lane_step = 1'b0;
    w_out_cur   = 1'b0;
    w_out_nxt   = 1'b0;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        if (w_seed_hs) w_state_nxt = SEED;
      end
      SEED: begin
        w_lane_load = 1'b1;
        w_state_nxt = WARM;
      end
      WARM: begin
        if (r_warm_cnt == '0) begin
          w_state_nxt = RUN;
          w_out_cur   = 1'b1;
          w_valid_nxt = 1'b1;
        end else begin
          w_lane_step = 1'b1;
        end
      end
      RUN: begin
        if (w_seed_hs) begin
          w_state_nxt = SEED;
          w_valid_nxt = 1'b0;
        end else if (EnxSI && !w_frozen) begin
          w_lane_step = 1'b1;
          w_out_nxt   = 1'b1;
          if (w_limit_hit) w_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      r_state    <= IDLE;
      r_warm_cnt <= '0;
      r_seed     <= '0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_ready <= (w_state_nxt == IDLE) || (w_state_nxt == RUN);
      if (w_seed_hs) r_seed <= SeedxDI;
      if (r_state == SEED) begin
        r_warm_cnt <= 32'(WARMUP_CYCLES);
      end else if (r_state == WARM && r_warm_cnt != '0) begin
        r_warm_cnt <= r_warm_cnt - 32'd1;
      end
      if (w_out_cur) begin
        r_out <= w_cat_cur;
      end else if (w_out_nxt) begin
        r_out <= w_cat_nxt;
      end
    end
  end

`ifdef DOM_RNG_RESEED_LIMIT_EN
  logic [31:0] r_step_cnt;
  logic        r_req;

  assign w_frozen    = r_req;
  assign w_limit_hit = (r_step_cnt == 32'(RESEED_LIMIT) - 32'd1);

  // The budget restarts with the handshake so the request drops immediately.
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      r_step_cnt <= '0;
      r_req      <= 1'b0;
    end else if (w_seed_hs || r_state == SEED) begin
      r_step_cnt <= '0;
      r_req      <= 1'b0;
    end else if (r_state == RUN && w_lane_step) begin
      r_step_cnt <= r_step_cnt + 32'd1;
      if (w_limit_hit) r_req <= 1'b1;
    end
  end

  assign ReseedReqxSO = r_req;
`else
  assign w_frozen    = 1'b0;
  assign w_limit_hit = 1'b0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [63:0] c_off   = 64'(i) * c_lane_inc;
    localparam int          c_out_w = ((c_tot - 64 * i) >= 64) ? 64 : (c_tot - 64 * i);
    logic [63:0] w_mix;
    logic [63:0] w_init;

    // xorshift has an all-zero fixed point, so a zero seed is substituted.
    assign w_mix  = r_seed ^ c_off;
    assign w_init = (w_mix == '0) ? c_zero_sub : w_mix;

    xorshift64_lane #(
      .OUT_W (c_out_w)
    ) u_lane (
      .clk        (ClkxCI),
      .rst        (RstxRI),
      .i_load     (w_lane_load),
      .i_load_val (w_init),
      .i_step     (w_lane_step),
      .o_state    (w_cat_cur[64*i +: c_out_w]),
      .o_next     (w_cat_nxt[64*i +: c_out_w])
    );
  end

  assign RandZxDO     = r_out[Z_W-1:0];
  assign RandBxDO     = r_out[Z_W +: B_W];
  assign RandValidxSO = r_valid;
  assign SeedReadyxSO = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_dom_mask_rng.sv
// ============================================================================
// Module  : tb_dom_mask_rng
// Purpose : Self-checking bench for dom_mask_rng: a one-lane, no-warmup
//           instance and a two-lane, warmup-5 instance driven in parallel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dom_mask_rng;

  localparam logic [63:0] GOLD = 64'h9E3779B97F4A7C15;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] seed_q;
  logic        sv;
  logic        en;

  logic [1:0]  z_a;
  logic [3:0]  b_a;
  logic        va, ra;
  logic [53:0] z_b;
  logic [53:0] b_b;
  logic        vb, rb;
`ifdef DOM_RNG_RESEED_LIMIT_EN
  logic        qa, qb;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dom_mask_rng #(
    .SHARES        (2),
    .NUM_MULS      (1),
    .WARMUP_CYCLES (0)
`ifdef DOM_RNG_RESEED_LIMIT_EN
    ,
    .RESEED_LIMIT  (4)
`endif
  ) u_dut_a (
    .ClkxCI       (clk),
    .RstxRI       (rst),
    .SeedxDI      (seed_q),
    .SeedValidxSI (sv),
    .SeedReadyxSO (ra),
    .EnxSI        (en),
    .RandZxDO     (z_a),
    .RandBxDO     (b_a),
    .RandValidxSO (va)
`ifdef DOM_RNG_RESEED_LIMIT_EN
    ,
    .ReseedReqxSO (qa)
`endif
  );

  dom_mask_rng #(
    .SHARES        (3),
    .NUM_MULS      (9),
    .WARMUP_CYCLES (5)
`ifdef DOM_RNG_RESEED_LIMIT_EN
    ,
    .RESEED_LIMIT  (4)
`endif
  ) u_dut_b (
    .ClkxCI       (clk),
    .RstxRI       (rst),
    .SeedxDI      (seed_q),
    .SeedValidxSI (sv),
    .SeedReadyxSO (rb),
    .EnxSI        (en),
    .RandZxDO     (z_b),
    .RandBxDO     (b_b),
    .RandValidxSO (vb)
`ifdef DOM_RNG_RESEED_LIMIT_EN
    ,
    .ReseedReqxSO (qb)
`endif
  );

  // ---------------- reference model (per instance d = 0 / 1) ----------------
  logic [63:0]  m_lane [2][2];
  logic [127:0] m_out  [2];
  bit           m_valid[2];
  bit           m_ready[2];
  int           m_busy [2];
  int           m_cnt  [2];
  bit           m_req  [2];
  bit           g_hs;

  function automatic int cfg_lanes(input int d); return (d == 0) ? 1 : 2;  endfunction
  function automatic int cfg_warm (input int d); return (d == 0) ? 0 : 5;  endfunction
  function automatic int cfg_zw   (input int d); return (d == 0) ? 2 : 54; endfunction
  function automatic int cfg_bw   (input int d); return (d == 0) ? 4 : 54; endfunction

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic logic [127:0] msk(input int w);
    logic [127:0] one;
    one = 128'd1;
    return (one << w) - one;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lane[d][0] = '0; m_lane[d][1] = '0;
      m_out[d] = '0; m_valid[d] = 0; m_ready[d] = 0;
      m_busy[d] = 0; m_cnt[d] = 0; m_req[d] = 0;
    end
  endtask

  task automatic model_edge(input int d, input bit s, input logic [63:0] seed, input bit e);
    logic [63:0] v;
    if (s && m_ready[d]) begin
      g_hs = 1;
      for (int i = 0; i < cfg_lanes(d); i++) begin
        v = seed ^ (64'(i) * GOLD);
        m_lane[d][i] = (v == 0) ? 64'd1 : v;
      end
      for (int k = 0; k < cfg_warm(d); k++)
        for (int i = 0; i < cfg_lanes(d); i++) m_lane[d][i] = xs(m_lane[d][i]);
      m_busy[d] = cfg_warm(d) + 2;
      m_valid[d] = 0; m_cnt[d] = 0; m_req[d] = 0;
    end else if (m_busy[d] > 0) begin
      m_busy[d]--;
      if (m_busy[d] == 0) begin
        m_valid[d] = 1;
        m_out[d] = {m_lane[d][1], m_lane[d][0]};
      end
    end else if (m_valid[d] && e) begin
      for (int i = 0; i < cfg_lanes(d); i++) m_lane[d][i] = xs(m_lane[d][i]);
      m_out[d] = {m_lane[d][1], m_lane[d][0]};
`ifdef DOM_RNG_RESEED_LIMIT_EN
      m_cnt[d]++;
      if (m_cnt[d] == 4) begin m_req[d] = 1; m_valid[d] = 0; end
`endif
    end
    m_ready[d] = (m_busy[d] == 0);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_dut(input int d, input logic v, input logic r, input logic [127:0] z,
                         input logic [127:0] b, input logic q);
    logic [127:0] ez;
    logic [127:0] eb;
    ez = m_out[d] & msk(cfg_zw(d));
    eb = (m_out[d] >> cfg_zw(d)) & msk(cfg_bw(d));
    chk($sformatf("dut%0d valid", d), 128'(v), 128'(m_valid[d]));
    chk($sformatf("dut%0d ready", d), 128'(r), 128'(m_ready[d]));
    chk($sformatf("dut%0d Z", d), z, ez);
    chk($sformatf("dut%0d B", d), b, eb);
`ifdef DOM_RNG_RESEED_LIMIT_EN
    chk($sformatf("dut%0d reseed_req", d), 128'(q), 128'(m_req[d]));
`else
    if (q) $display("unexpected request flag");
`endif
  endtask

  task automatic check_all();
`ifdef DOM_RNG_RESEED_LIMIT_EN
    chk_dut(0, va, ra, 128'(z_a), 128'(b_a), qa);
    chk_dut(1, vb, rb, 128'(z_b), 128'(b_b), qb);
`else
    chk_dut(0, va, ra, 128'(z_a), 128'(b_a), 1'b0);
    chk_dut(1, vb, rb, 128'(z_b), 128'(b_b), 1'b0);
`endif
  endtask

  // Inputs change on the falling edge; outputs are compared one falling edge later.
  task automatic cycle(input bit s, input logic [63:0] seed, input bit e);
    sv = s; seed_q = seed; en = e;
    @(posedge clk);
    g_hs = 0;
    for (int d = 0; d < 2; d++) model_edge(d, s, seed, e);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; sv = 0; en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 0;
    cycle(1'b0, seed_q, 1'b0);
  endtask

  typedef struct {
    logic [63:0] seed;
    int          pulses;
    logic [1:0]  z;
    logic [3:0]  b;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb;
    bit da, db;
    bit s;
    logic [63:0] sd;

    rst = 1; sv = 0; en = 0; seed_q = '0;
    tbl[0] = '{64'h1,                 0, 2'b01, 4'b0000};
    tbl[1] = '{64'h0,                 0, 2'b01, 4'b0000};
    tbl[2] = '{64'h1,                 1, 2'b01, 4'b0000};
    tbl[3] = '{64'h3F,                0, 2'b11, 4'b1111};
    tbl[4] = '{64'h2A,                0, 2'b10, 4'b1010};
    tbl[5] = '{64'hFFFFFFFFFFFFFFC4,  0, 2'b00, 4'b0001};

    do_reset();
    chk("release ready A", 128'(ra), 128'd1);
    chk("release valid A", 128'(va), 128'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      cycle(1'b1, tbl[i].seed, 1'b0);
      cycle(1'b0, tbl[i].seed, 1'b0);
      chk($sformatf("tbl%0d valid@hs+1", i), 128'(va), 128'd0);
      cycle(1'b0, tbl[i].seed, 1'b0);
      chk($sformatf("tbl%0d valid@hs+2", i), 128'(va), 128'd1);
      for (int p = 0; p < tbl[i].pulses; p++) cycle(1'b0, tbl[i].seed, 1'b1);
      cycle(1'b0, tbl[i].seed, 1'b0);
      chk($sformatf("tbl%0d Z", i), 128'(z_a), 128'(tbl[i].z));
      chk($sformatf("tbl%0d B", i), 128'(b_a), 128'(tbl[i].b));
    end

    // First step from seed 1 seen through the wide instance's lane 0.
    do_reset();
    cycle(1'b1, 64'h1, 1'b0);
    repeat (8) cycle(1'b0, 64'h1, 1'b0);
    repeat (10) cycle(1'b0, 64'h1, 1'b0);
    chk("hold Z B-inst", 128'(z_b), m_out[1] & msk(54));
    chk("hold valid B-inst", 128'(vb), 128'd1);
    repeat (3) cycle(1'b0, 64'h1, 1'b1);

    // Reseed while running: count the invalid gap on each instance.
    cycle(1'b1, 64'hDEADBEEF, 1'b0);
    na = 0; nb = 0; da = 0; db = 0;
    if (!va) na++; else da = 1;
    if (!vb) nb++; else db = 1;
    for (int k = 0; k < 30 && !(da && db); k++) begin
      cycle(1'b0, 64'hDEADBEEF, 1'b0);
      if (!da) begin if (!va) na++; else da = 1; end
      if (!db) begin if (!vb) nb++; else db = 1; end
    end
    chk("reseed gap A", 128'(na), 128'd2);
    chk("reseed gap B", 128'(nb), 128'd7);
    repeat (4) cycle(1'b0, 64'hDEADBEEF, 1'b1);

    // Asynchronous reset while the wide instance is warming up.
    cycle(1'b1, 64'h0123456789ABCDEF, 1'b0);
    cycle(1'b0, 64'h0123456789ABCDEF, 1'b0);
    cycle(1'b0, 64'h0123456789ABCDEF, 1'b1);
    #2 rst = 1;
    #1;
    chk("async rst valid A", 128'(va), 128'd0);
    chk("async rst Z A", 128'(z_a), 128'd0);
    chk("async rst valid B", 128'(vb), 128'd0);
    chk("async rst ready B", 128'(rb), 128'd0);
    chk("async rst Z B", 128'(z_b), 128'd0);
    chk("async rst B B", 128'(b_b), 128'd0);
    do_reset();

`ifdef DOM_RNG_RESEED_LIMIT_EN
    cycle(1'b1, 64'h55, 1'b0);
    repeat (8) cycle(1'b0, 64'h55, 1'b0);
    repeat (4) cycle(1'b0, 64'h55, 1'b1);
    chk("limit req A", 128'(qa), 128'd1);
    chk("limit valid A", 128'(va), 128'd0);
    chk("limit req B", 128'(qb), 128'd1);
    repeat (3) cycle(1'b0, 64'h55, 1'b1);
    cycle(1'b1, 64'h77, 1'b0);
    chk("limit cleared A", 128'(qa), 128'd0);
    chk("limit cleared B", 128'(qb), 128'd0);
    repeat (8) cycle(1'b0, 64'h77, 1'b1);
`endif

    // Randomized run against the model.
    do_reset();
    sd = 64'h1;
    for (int k = 0; k < 2000; k++) begin
      s = !g_hs && ($urandom_range(0, 29) == 0);
      if (s) begin
        sd = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
      end
      cycle(s, sd, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
